// File: rtl/square_rem.sv
// Iterative shift-add squarer: REG_OUT = ROOT_IN^2 (+ REM_IN), one root bit per cycle, MSB first.
// Shares the CHP/BUSY start handshake with the square-root unit so its (root, remainder) can be fed back.
module square_rem #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CHP,
  input  logic [WIDTH-1:0]   ROOT_IN,
  input  logic [WIDTH:0]     REM_IN,
  input  logic               ADD_REM,
  output logic [2*WIDTH-1:0] REG_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVF,
  output logic               INVALID,
  output logic [2*WIDTH:0]   DEBUG
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [AW-1:0]    acc;
  logic [IW-1:0]    iter;
  logic             inv;

  logic [AW-1:0]    acc_next;
  logic [AW-1:0]    sum;
  logic             q_bit;

  // One partial product per cycle; the final remainder add is kept at full width so OVF is exact.
  always_comb begin
    q_bit    = q[LAST - iter];
    acc_next = {acc[AW-2:0], 1'b0} + (q_bit ? {{(WIDTH+1){1'b0}}, q} : '0);
    sum      = acc_next + {{WIDTH{1'b0}}, r};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      q       <= '0;
      r       <= '0;
      acc     <= '0;
      iter    <= '0;
      inv     <= 1'b0;
      REG_OUT <= '0;
      DONE    <= 1'b0;
      OVF     <= 1'b0;
      INVALID <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (CHP) begin
            q     <= ROOT_IN;
            r     <= ADD_REM ? REM_IN : '0;
            acc   <= '0;
            iter  <= '0;
            inv   <= ADD_REM && (REM_IN > {ROOT_IN, 1'b0});
            state <= RUN;
          end
        end
        RUN: begin
          if (iter == LAST) begin
            REG_OUT <= sum[AW-2:0];
            OVF     <= sum[AW-1];
            INVALID <= inv;
            DONE    <= 1'b1;
            state   <= IDLE;
          end else begin
            acc  <= acc_next;
            iter <= iter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY  = (state == RUN);
  assign DEBUG = acc;

endmodule

// File: tb/tb_square_rem.sv
// Scoreboard bench for square_rem: expected results are queued at each start and popped on DONE.
module tb_square_rem;

  localparam int WIDTH = 16;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               CHP;
  logic [WIDTH-1:0]   ROOT_IN;
  logic [WIDTH:0]     REM_IN;
  logic               ADD_REM;
  logic [2*WIDTH-1:0] REG_OUT;
  logic               BUSY;
  logic               DONE;
  logic               OVF;
  logic               INVALID;
  logic [2*WIDTH:0]   DEBUG;

  square_rem #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .CHP(CHP), .ROOT_IN(ROOT_IN), .REM_IN(REM_IN),
    .ADD_REM(ADD_REM), .REG_OUT(REG_OUT), .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
    .INVALID(INVALID), .DEBUG(DEBUG)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] reg_v;
    logic        ovf;
    logic        inv;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [15:0] q, input logic [16:0] r,
                                 input logic add, input int c);
    exp_t   e;
    longint s;
    s       = longint'(q) * longint'(q) + (add ? longint'(r) : 64'sd0);
    e.reg_v = s[31:0];
    e.ovf   = s[32];
    e.inv   = add && (longint'(r) > 2 * longint'(q));
    e.cyc   = c;
    return e;
  endfunction

  function automatic longint isqrt(input longint x);
    longint res, t;
    res = 0;
    for (int b = 15; b >= 0; b--) begin
      t = res | (longint'(1) << b);
      if (t * t <= x) res = t;
    end
    return res;
  endfunction

  task automatic start(input logic [15:0] q, input logic [16:0] r, input logic add);
    @(negedge CLK);
    ROOT_IN = q; REM_IN = r; ADD_REM = add; CHP = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CHP = 1'b0;
    sb.push_back(model(q, r, add, cyc + WIDTH));
  endtask

  task automatic await_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; CHP = 1'b0; ROOT_IN = '0; REM_IN = '0; ADD_REM = 1'b0;
    #12;
    checks += 6;
    if (REG_OUT !== 32'd0) begin errors++; $display("FAIL reset_reg got %0h want 0", REG_OUT); end
    if (BUSY !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    if (DONE !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
    if (OVF !== 1'b0)      begin errors++; $display("FAIL reset_ovf got %b want 0", OVF); end
    if (INVALID !== 1'b0)  begin errors++; $display("FAIL reset_inv got %b want 0", INVALID); end
    if (DEBUG !== 33'd0)   begin errors++; $display("FAIL reset_debug got %0h want 0", DEBUG); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_zero;
    bit seen;
    exp_t e;
    start(16'd0, 17'd0, 1'b1);
    await_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL zero_timeout got no DONE want DONE"); end
    else begin
      e = sb.pop_front();
      checks += 5;
      if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL zero_reg got %0d want %0d", REG_OUT, e.reg_v); end
      if (OVF !== e.ovf)       begin errors++; $display("FAIL zero_ovf got %b want %b", OVF, e.ovf); end
      if (INVALID !== e.inv)   begin errors++; $display("FAIL zero_inv got %b want %b", INVALID, e.inv); end
      if (cyc !== e.cyc)       begin errors++; $display("FAIL zero_latency got %0d want %0d", cyc, e.cyc); end
      @(negedge CLK);
      if (DONE !== 1'b0)       begin errors++; $display("FAIL zero_done_pulse got %b want 0", DONE); end
    end
  endtask

  task automatic test_no_rem;
    bit seen;
    exp_t e;
    start(16'd12345, 17'd99999, 1'b0);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL norem_busy got %b want 1", BUSY); end
    await_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL norem_timeout got no DONE want DONE"); end
    else begin
      e = sb.pop_front();
      checks += 5;
      if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL norem_reg got %0d want %0d", REG_OUT, e.reg_v); end
      if (REG_OUT !== 32'd152399025) begin errors++; $display("FAIL norem_const got %0d want 152399025", REG_OUT); end
      if (INVALID !== 1'b0)    begin errors++; $display("FAIL norem_inv got %b want 0", INVALID); end
      if (cyc !== e.cyc)       begin errors++; $display("FAIL norem_latency got %0d want %0d", cyc, e.cyc); end
      if (BUSY !== 1'b0)       begin errors++; $display("FAIL norem_busy_fall got %b want 0", BUSY); end
    end
  endtask

  task automatic test_boundary;
    bit seen;
    exp_t e;
    logic [16:0] rems [2];
    rems[0] = 17'd131070;
    rems[1] = 17'd131071;
    for (int k = 0; k < 2; k++) begin
      start(16'd65535, rems[k], 1'b1);
      await_done(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL bound%0d_timeout got no DONE want DONE", k); end
      else begin
        e = sb.pop_front();
        checks += 3;
        if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL bound%0d_reg got %0h want %0h", k, REG_OUT, e.reg_v); end
        if (OVF !== e.ovf)       begin errors++; $display("FAIL bound%0d_ovf got %b want %b", k, OVF, e.ovf); end
        if (INVALID !== e.inv)   begin errors++; $display("FAIL bound%0d_inv got %b want %b", k, INVALID, e.inv); end
      end
    end
  endtask

  task automatic test_invalid;
    bit seen;
    exp_t e;
    start(16'd3, 17'd7, 1'b1);
    await_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL inv_timeout got no DONE want DONE"); end
    else begin
      e = sb.pop_front();
      checks += 3;
      if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL inv_reg got %0d want %0d", REG_OUT, e.reg_v); end
      if (INVALID !== e.inv)   begin errors++; $display("FAIL inv_flag got %b want %b", INVALID, e.inv); end
      if (OVF !== e.ovf)       begin errors++; $display("FAIL inv_ovf got %b want %b", OVF, e.ovf); end
    end
  endtask

  task automatic test_chp_ignore;
    exp_t e;
    int dn, dcyc;
    dn = 0; dcyc = -1;
    start(16'd500, 17'd7, 1'b1);
    for (int n = 0; n < 40; n++) begin
      CHP = (n == 4 || n == 15);
      ROOT_IN = 16'd999;
      @(negedge CLK);
      if (DONE) begin dn++; dcyc = cyc; end
    end
    CHP = 1'b0;
    e = sb.pop_front();
    checks += 4;
    if (dn !== 1)            begin errors++; $display("FAIL chp_done_count got %0d want 1", dn); end
    if (dcyc !== e.cyc)      begin errors++; $display("FAIL chp_done_cycle got %0d want %0d", dcyc, e.cyc); end
    if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL chp_reg got %0d want %0d", REG_OUT, e.reg_v); end
    if (BUSY !== 1'b0)       begin errors++; $display("FAIL chp_busy got %b want 0", BUSY); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int dn;
    logic [15:0] qs [3];
    logic [16:0] rs [3];
    qs[0] = 16'd40000; rs[0] = 17'd17;
    qs[1] = 16'd257;   rs[1] = 17'd500;
    qs[2] = 16'd65000; rs[2] = 17'd1;
    dn = 0;
    @(negedge CLK);
    ROOT_IN = qs[0]; REM_IN = rs[0]; ADD_REM = 1'b1; CHP = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    sb.push_back(model(qs[0], rs[0], 1'b1, cyc + WIDTH));
    for (int n = 0; n < 70 && dn < 3; n++) begin
      if (DONE) begin
        e = sb.pop_front();
        checks += 3;
        if (REG_OUT !== e.reg_v) begin errors++; $display("FAIL b2b%0d_reg got %0d want %0d", dn, REG_OUT, e.reg_v); end
        if (INVALID !== e.inv)   begin errors++; $display("FAIL b2b%0d_inv got %b want %b", dn, INVALID, e.inv); end
        if (cyc !== e.cyc)       begin errors++; $display("FAIL b2b%0d_cycle got %0d want %0d", dn, cyc, e.cyc); end
        dn++;
        if (dn < 3) begin
          ROOT_IN = qs[dn]; REM_IN = rs[dn];
          sb.push_back(model(qs[dn], rs[dn], 1'b1, cyc + 1 + WIDTH));
        end else CHP = 1'b0;
      end
      @(negedge CLK);
    end
    CHP = 1'b0;
    checks++;
    if (dn !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", dn); end
    sb.delete();
  endtask

  task automatic test_reset_mid;
    bit seen;
    exp_t e;
    start(16'd4000, 17'd5, 1'b1);
    repeat (8) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks += 6;
    if (REG_OUT !== 32'd0) begin errors++; $display("FAIL midrst_reg got %0h want 0", REG_OUT); end
    if (BUSY !== 1'b0)     begin errors++; $display("FAIL midrst_busy got %b want 0", BUSY); end
    if (DONE !== 1'b0)     begin errors++; $display("FAIL midrst_done got %b want 0", DONE); end
    if (OVF !== 1'b0)      begin errors++; $display("FAIL midrst_ovf got %b want 0", OVF); end
    if (INVALID !== 1'b0)  begin errors++; $display("FAIL midrst_inv got %b want 0", INVALID); end
    if (DEBUG !== 33'd0)   begin errors++; $display("FAIL midrst_debug got %0h want 0", DEBUG); end
    sb.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || REG_OUT !== 32'd0) begin
      errors++; $display("FAIL midrst_nodone got done=%b reg=%0h want 0/0", DONE, REG_OUT);
    end
    start(16'd1000, 17'd0, 1'b1);
    await_done(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_timeout got no DONE want DONE"); end
    else begin
      e = sb.pop_front();
      checks += 2;
      if (REG_OUT !== 32'd1000000) begin errors++; $display("FAIL midrst_reg2 got %0d want 1000000", REG_OUT); end
      if (cyc !== e.cyc)           begin errors++; $display("FAIL midrst_latency got %0d want %0d", cyc, e.cyc); end
    end
  endtask

  task automatic test_round_trip;
    bit seen;
    exp_t e;
    logic [31:0] x;
    longint q, r;
    for (int i = 0; i < 8; i++) begin
      x = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      q = isqrt(longint'(x));
      r = longint'(x) - q * q;
      start(q[15:0], r[16:0], 1'b1);
      await_done(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL rt%0d_timeout got no DONE want DONE", i); end
      else begin
        e = sb.pop_front();
        checks += 3;
        if (REG_OUT !== x)     begin errors++; $display("FAIL rt%0d_reg got %0h want %0h", i, REG_OUT, x); end
        if (INVALID !== 1'b0)  begin errors++; $display("FAIL rt%0d_inv got %b want 0", i, INVALID); end
        if (OVF !== e.ovf)     begin errors++; $display("FAIL rt%0d_ovf got %b want %b", i, OVF, e.ovf); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_no_rem();
    test_boundary();
    test_invalid();
    test_chp_ignore();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/square_rem.md
# square_rem

Iterative shift-add squarer that rebuilds a radicand from an integer root and optional remainder: REG_OUT = ROOT_IN² (+ REM_IN). It is the inverse of the pipeline's 16-iteration square-root unit. It uses the same CHP/BUSY start handshake, so a sqrt result (root, remainder) can be fed straight back for round-trip checking or reconstruction. It processes one root bit per cycle, MSB first.

## Interface
- WIDTH, 16, root width in bits; result width is 2·WIDTH, remainder width is WIDTH+1.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- CHP  in  1  start strobe; sampled only when BUSY=0.
- ROOT_IN  in  WIDTH  root q; captured at start.
- REM_IN  in  WIDTH+1  remainder r; captured at start.
- ADD_REM  in  1  1 = add r to q²; captured at start.
- REG_OUT  out  2·WIDTH  result; holds until the next completion.
- BUSY  out  1  high while iterating.
- DONE  out  1  one-cycle pulse when REG_OUT updates.
- OVF  out  1  the true sum exceeded 2·WIDTH bits; updates with REG_OUT.
- INVALID  out  1  r > 2q (not a legal sqrt remainder); updates with REG_OUT.
- DEBUG  out  2·WIDTH+1  current accumulator value.

## Operation
- States: IDLE (BUSY=0) and RUN (BUSY=1).
- IDLE → RUN on a clock edge with CHP=1 and BUSY=0. That edge does the following:
  - latches q, r (forced to 0 if ADD_REM=0), and ADD_REM;
  - clears acc (2·WIDTH+1 bits) and iteration;
  - registers inv = (REM_IN > {ROOT_IN,1'b0}), as a WIDTH+1-bit unsigned compare, masked by ADD_REM.
- Each RUN cycle computes, combinationally: acc_next = (acc << 1) + (q[WIDTH-1-iteration] ? q : 0).
  - After WIDTH steps, acc = q², which always fits in 2·WIDTH bits.
- On the RUN edge with iteration = WIDTH-1:
  - sum = acc_next + r, computed at 2·WIDTH+1 bits;
  - REG_OUT ← sum[2·WIDTH-1:0], wrapping on overflow;
  - OVF ← sum[2·WIDTH];
  - INVALID ← inv;
  - DONE ← 1, BUSY ← 0, then return to IDLE.
- Otherwise each RUN edge does acc ← acc_next and iteration ← iteration+1.
- CHP while BUSY=1 is ignored. There is no queuing, and inputs may change freely during RUN.
- OVF=1 implies INVALID=1: for r ≤ 2q, q²+r ≤ (q+1)²−1 < 2^(2·WIDTH).
- DONE is cleared on every edge where it is not being set.

## Timing
- Reset (RST_N=0, asynchronous): REG_OUT=0, BUSY=0, DONE=0, OVF=0, INVALID=0, acc=0, iteration=0.
  - Reset mid-RUN aborts at once with no DONE; the next start after release behaves normally.
- Start accepted at edge E0; BUSY=1 from E0 to E_WIDTH, i.e. exactly WIDTH cycles.
- REG_OUT, OVF, INVALID and DONE update at edge E_WIDTH; BUSY falls at the same edge.
- CHP held high through E_WIDTH is not accepted at that edge, because BUSY is still 1 when sampled. It is accepted at E_WIDTH+1.
  - Back-to-back throughput is therefore one result per WIDTH+1 cycles.
- DEBUG is combinational from acc and is valid every cycle.

## Test plan
- Reset, then ROOT_IN=0, REM_IN=0, ADD_REM=1 → after 16 cycles REG_OUT=0, DONE pulses once, OVF=0, INVALID=0.
- ROOT_IN=12345, ADD_REM=0, REM_IN=99999 → REG_OUT=152399025 exactly 16 cycles after the start edge. The remainder is ignored and INVALID=0.
- ROOT_IN=65535, REM_IN=131070, ADD_REM=1 → REG_OUT=0xFFFFFFFF, OVF=0, INVALID=0. Then REM_IN=131071 → REG_OUT=0, OVF=1, INVALID=1.
- ROOT_IN=3, REM_IN=7, ADD_REM=1 → REG_OUT=16, INVALID=1, OVF=0.
- Handshake:
  - pulse CHP at cycles 0, 5 and 16 → only the cycle-0 start runs, and REG_OUT is unchanged by the others;
  - CHP held high continuously → starts at E0, E17, E34.
- Reset and round trip:
  - drop RST_N after 8 iterations → all outputs 0 immediately, no DONE;
  - after release, run root 1000 / remainder 0 → REG_OUT=1000000;
  - a random sweep of x fed through sqrt then square_rem must return x with INVALID=0.
